// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: PC select encoding, sequencer states and the PC step.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned PcInc = 4;

  typedef enum logic [1:0] {
    SelHold,
    SelRedirect,
    SelRas,
    SelSeq
  } pc_sel_t;

  typedef enum logic {
    StRun,
    StHalted
  } seq_state_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d, wr_idx;
  logic [CntW-1:0] count_q, count_d;
  logic            we, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  // Entries are never reset, so the top is masked while nothing is stored.
  assign top   = empty ? '0 : mem[ptr_q];

  always_comb begin
    do_pop  = pop && !empty;
    ptr_d   = ptr_q;
    count_d = count_q;
    we      = 1'b0;
    wr_idx  = ptr_q;
    if (push && do_pop) begin
      we = 1'b1;
    end else if (push) begin
      ptr_d  = ptr_q + PtrW'(1);
      wr_idx = ptr_q + PtrW'(1);
      we     = 1'b1;
      if (!full) count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      ptr_d   = ptr_q - PtrW'(1);
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
    end else if (we) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential/redirect/return selection with a return-address stack
// and a sticky halt that only reset clears.
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned      PC_W      = 32,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pcen,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            push_en,
  input  logic            pop_en,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  localparam logic [PC_W-1:0] AlignMask = ~PC_W'(3);

  seq_state_t      state_q, state_d;
  pc_sel_t         pc_sel;
  logic [PC_W-1:0] pc_q, pc_d, ras_top;
  logic            active, ras_push, ras_pop;
  logic            underflow_q, underflow_d;

  assign pc            = pc_q;
  assign npc           = pc_q + PC_W'(PcInc);
  assign halted        = (state_q == StHalted);
  assign ras_underflow = underflow_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    // Halt wins over every other request, even with pcen low.
    active  = (state_q == StRun) && pcen && !halt;
    if ((state_q == StRun) && halt) state_d = StHalted;

    ras_push    = active && push_en;
    ras_pop     = active && pop_en;
    underflow_d = ras_pop && ras_empty;

    if (!active)                     pc_sel = SelHold;
    else if (redirect_en)            pc_sel = SelRedirect;
    else if (pop_en && !ras_empty)   pc_sel = SelRas;
    else                             pc_sel = SelSeq;

    unique case (pc_sel)
      SelHold:     pc_d = pc_q;
      SelRedirect: pc_d = redirect_pc & AlignMask;
      SelRas:      pc_d = ras_top & AlignMask;
      SelSeq:      pc_d = npc;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      underflow_q <= underflow_d;
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .CLK  (CLK),
    .nRST (nRST),
    .push (ras_push),
    .pop  (ras_pop),
    .din  (npc),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 32, width of the PC and of all address ports.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset; low 2 bits SHALL be zero.
REQ-003 Parameter RAS_DEPTH, default 8, return-address-stack entries; power of two, >= 2.
REQ-004 CLK  input  1  system clock, rising-edge active.
REQ-005 nRST  input  1  reset; asynchronous, active-low.
REQ-006 pcen  input  1  advance enable; 0 = stall, PC and RAS hold.
REQ-007 redirect_en  input  1  branch/jump taken this cycle.
REQ-008 redirect_pc  input  PC_W  redirect target.
REQ-009 push_en  input  1  call: push npc onto the RAS.
REQ-010 pop_en  input  1  return: next PC is taken from the RAS top.
REQ-011 halt  input  1  halt request.
REQ-012 pc  output  PC_W  current fetch address (registered).
REQ-013 npc  output  PC_W  pc + 4 (combinational).
REQ-014 halted  output  1  sticky halt status (registered).
REQ-015 ras_empty  output  1  RAS holds 0 entries.
REQ-016 ras_full  output  1  RAS holds RAS_DEPTH entries.
REQ-017 ras_underflow  output  1  one-cycle registered pulse; a pop was attempted on an empty RAS.

Function
REQ-018 The block SHALL have two states: RUN (after reset) and HALTED.
REQ-019 RUN->HALTED on any rising CLK with halt=1, regardless of pcen; HALTED SHALL exit only via reset.
REQ-020 In HALTED, pc, the RAS and its count SHALL hold; push_en, pop_en, redirect_en and pcen SHALL be ignored.
REQ-021 In RUN with pcen=1, the next pc SHALL be selected by priority: halt (hold pc) > redirect_en (redirect_pc) > pop_en with non-empty RAS (RAS top) > npc.
REQ-022 In RUN with pcen=0, pc and the RAS SHALL hold and all request inputs SHALL be ignored, except halt.
REQ-023 Loaded targets (redirect_pc, RAS top) SHALL have bits [1:0] forced to 0.
REQ-024 npc SHALL wrap modulo 2^PC_W (pc = 2^PC_W-4 gives npc = 0).
REQ-025 A push (RUN, pcen=1, halt=0, push_en=1) SHALL store the current npc; pushes SHALL be honoured even when redirect_en=1.
REQ-026 A push when full SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH and ras_full stays 1.
REQ-027 A pop SHALL decrement the count and expose the next-older entry as the new top.
REQ-028 A pop when empty SHALL take the npc path (unless redirect_en=1), leave the count at 0, and set ras_underflow for the next cycle.
REQ-029 A pop is consumed even if redirect_en wins the PC select: count decrements and the popped value is discarded.
REQ-030 A simultaneous push and pop SHALL replace the top entry with npc, leave the count unchanged, and use the old top as the target under REQ-021.
REQ-031 ras_empty and ras_full SHALL derive from a registered count of width $clog2(RAS_DEPTH)+1.

Reset
REQ-032 On nRST=0, immediately: pc = RESET_PC, state = RUN, halted = 0, RAS count = 0, top pointer = 0, ras_underflow = 0, ras_empty = 1, ras_full = 0.
REQ-033 RAS entry contents SHALL NOT need reset; no output may depend on an entry while count = 0.
REQ-034 Reset asserted mid-operation, including in HALTED, SHALL abort all activity with no residual state.

Structure
REQ-035 pc_sel_t (HOLD, REDIRECT, RAS, SEQ) and the PC increment constant (4) SHALL live in cpu_types_pkg; word_t SHALL be used when PC_W = 32.
REQ-036 The RAS SHALL be a sub-module ras_stack (params DEPTH, W; ports push, pop, din, top, empty, full), instantiated once.
REQ-037 Next-PC select SHALL be a single always_comb block; all state SHALL reside in always_ff blocks sensitive to posedge CLK, negedge nRST.

Verification
REQ-038 Reset, then 3 cycles with pcen=1 and no requests: pc goes 0 -> 4 -> 8 -> C; npc = 10.
REQ-039 At pc=0x20, assert push_en and redirect_pc=0x100 together, then assert pop_en at pc=0x104: pc goes 0x100, 0x104, 0x24; ras_empty ends at 1.
REQ-040 With RAS_DEPTH=8, do 9 pushes of npc values A1..A9, then 9 pops: the first 8 pops return A9..A2 and the 9th pop gives pc+4 with ras_underflow=1 for one cycle.
REQ-041 Assert halt together with redirect_en while pcen=0: pc holds and halted=1; later pcen, redirect_en and pop_en have no effect until nRST pulses, after which pc = RESET_PC.
REQ-042 With pcen=0 and push_en=1 for 5 cycles, the count stays unchanged; at pc=0xFFFFFFFC, pcen=1 gives pc = 0 (wrap).
